uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter, the transmit-side counterpart of the existing uart_rx. It accepts bytes over a valid/ready handshake into a small internal FIFO and serialises them on a single line: start bit, data bits LSB first, optional parity, then stop bit(s). It runs on the same system clock as the receiver (sck) and is used for telemetry and status reporting back to the host link.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, at least 2.

Ports:
clk  input  1  system clock; all logic is rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
data_in  input  8  byte to send; only bits [DATA_BITS-1:0] are transmitted.
valid  input  1  data_in is valid this cycle.
ready  output  1  FIFO can accept a byte (high when not full).
tx  output  1  serial line; idle high; registered.
busy  output  1  high while a frame is in progress or the FIFO is non-empty.
count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, ready=1, busy=0, count=0. FIFO is emptied, the FSM goes to IDLE and all counters clear. Asserting reset mid-frame truncates the frame immediately, with tx=1 on assertion.
- Accept: a byte is written when valid && ready at a rising edge. ready = !full, derived from the registered count only; it does not depend on a same-cycle pop. valid while full is ignored and the byte is dropped, which is legal.
- Simultaneous push and pop in one cycle (count not full): count is unchanged and both take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, compute parity, go to START and drive tx=0 on that same edge.
- Latency: a byte accepted into an empty FIFO while in IDLE at edge N gives tx=0 from edge N+1.
- Each bit is held for exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
- START: tx=0, then go to DATA.
- DATA: shift out DATA_BITS bits, LSB first. Afterwards go to PARITY if PARITY!=0, else go to STOP.
- PARITY: tx = XOR of the data bits, inverted for odd parity (the data bits plus the parity bit contain an odd number of ones).
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of the last stop cycle: if the FIFO is non-empty, pop and enter START on that edge, so frames run back-to-back with no idle gap. Otherwise go to IDLE.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- busy is registered: 1 from the edge after any accept or while state != IDLE; 0 once in IDLE with count=0.
- FIFO pointers wrap modulo FIFO_DEPTH. count is exact and saturates at neither end, because push is blocked when full and pop is blocked when empty.
- valid or data_in changing mid-frame has no effect on the frame in progress.

Test Plan:
All tests use CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4 unless stated otherwise.
1. Reset: hold reset=0 with valid=1 -> tx=1, ready=1, busy=0, count=0 throughout. Release reset -> no frame until an accept occurs.
2. Single byte 0x35, PARITY=0, STOP_BITS=1: tx goes low 1 cycle after the accept. The frame is 0,1,0,1,0,1,1,0,0,1, each bit exactly 4 cycles, 40 cycles total. Then tx=1 and busy=0.
3. Parity: with PARITY=2 send 0x35 -> parity bit 0. With PARITY=1 send 0x35 -> parity bit 1. With STOP_BITS=2 -> frame is 48 cycles.
4. FIFO full / back-to-back: push 0xA5, 0x0F, 0xFF, 0x00, 0x81 on consecutive cycles.
   - The first four are accepted; after the first pop one slot frees, so the 5th is accepted when ready returns.
   - ready=0 while count=4; the byte offered in that cycle is dropped.
   - Frames appear in order with stop bit directly followed by start bit: no idle cycle between frames.
5. Simultaneous push/pop: push a byte exactly on the edge the FSM pops (end of stop bit) with count=1 -> count stays 1 and the data order is preserved.
6. Reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately (asynchronous), FIFO empty. After release, a new byte 0x5A transmits a clean 40-cycle frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO in front of a start/data/parity/stop serialiser.
// tx is registered and idles high; frames from a non-empty FIFO run back-to-back.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_n;
  logic [15:0]     baud, baud_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shift, shift_n, head;
  logic            par_bit, par_n, head_par;
  logic            tx_n, push, pop, bit_done;

  assign ready    = (count != DEPTH_C);
  assign push     = valid && ready;
  assign head     = mem[rd_ptr] & DATA_MASK;
  assign head_par = (^head) ^ ODD_PAR;
  assign bit_done = (baud == BAUD_LAST);
  assign count_n  = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
    shift   <= shift_n;
    par_bit <= par_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr  <= pop  ? rd_ptr + 1'b1 : rd_ptr;
      count   <= count_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      tx      <= tx_n;
      busy    <= (state_n != S_IDLE) || (count_n != '0);
    end
  end

  // Every bit boundary reloads the baud counter; a pop always enters START with tx low.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = tx;
    baud_n  = bit_done ? 16'd0 : baud + 16'd1;
    bit_n   = bit_idx;
    shift_n = shift;
    par_n   = par_bit;
    case (state)
      S_IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S_START;
          tx_n    = 1'b0;
          shift_n = head;
          par_n   = head_par;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_n = S_DATA;
          tx_n    = shift[0];
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx == DATA_LAST) begin
            bit_n = '0;
            if (PARITY != 0) begin
              state_n = S_PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            shift_n = shift >> 1;
            tx_n    = shift[1];
            bit_n   = bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (bit_idx == STOP_LAST) begin
            bit_n = '0;
            if (count != '0) begin
              pop     = 1'b1;
              state_n = S_START;
              tx_n    = 1'b0;
              shift_n = head;
              par_n   = head_par;
            end else begin
              state_n = S_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no parity/1 stop, even/1 stop, odd/2 stop)
// with a byte scoreboard checked sample-by-sample against a frame model.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] valid = 3'b000;
  logic [2:0] ready, tx, busy;
  logic [2:0] count0, count1, count2;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid[0]),
    .ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .count(count0));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid[1]),
    .ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .count(count1));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid[2]),
    .ready(ready[2]), .tx(tx[2]), .busy(busy[2]), .count(count2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one clock; the scoreboard only learns bytes that must appear on the line.
  task automatic push(input int idx, input logic [7:0] b, input bit expect_sent);
    data_in    = b;
    valid[idx] = 1'b1;
    if (expect_sent) sb.push_back(b);
    @(negedge clk);
    valid[idx] = 1'b0;
  endtask

  function automatic logic model_bit(input logic [7:0] b, input int par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par != 0) return (^b) ^ (par == 1);
    return 1'b1;
  endfunction

  task automatic check_frame(input int idx, input bit immediate, input string tag);
    int par, stops, nbits, waited;
    logic [7:0] b;
    par   = (idx == 1) ? 2 : (idx == 2) ? 1 : 0;
    stops = (idx == 2) ? 2 : 1;
    nbits = 1 + 8 + ((par != 0) ? 1 : 0) + stops;
    @(negedge clk);
    waited = 0;
    if (!immediate)
      while (tx[idx] !== 1'b0 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    b = sb.pop_front();
    for (int k = 0; k < nbits; k++)
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        chk($sformatf("%s_byte%02h_bit%0d_cyc%0d", tag, b, k, c), 32'(tx[idx]),
            32'(model_bit(b, par, k)));
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with valid asserted
    valid = 3'b001;
    data_in = 8'h35;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx[0]), 32'd1);
      chk("rst_ready", 32'(ready[0]), 32'd1);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_count", 32'(count0), 32'd0);
    end
    valid = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx[0]), 32'd1);
      chk("idle_busy", 32'(busy[0]), 32'd0);
    end

    // single byte, exact latency and timing
    push(0, 8'h35, 1'b1);
    chk("lat_tx_still_high", 32'(tx[0]), 32'd1);
    chk("lat_busy", 32'(busy[0]), 32'd1);
    chk("lat_count", 32'(count0), 32'd1);
    check_frame(0, 1'b1, "single");
    @(negedge clk);
    chk("single_end_tx", 32'(tx[0]), 32'd1);
    chk("single_end_busy", 32'(busy[0]), 32'd0);
    chk("single_end_count", 32'(count0), 32'd0);

    // parity variants
    push(1, 8'h35, 1'b1);
    check_frame(1, 1'b1, "even");
    @(negedge clk);
    chk("even_end_busy", 32'(busy[1]), 32'd0);
    push(2, 8'h35, 1'b1);
    check_frame(2, 1'b1, "odd2stop");
    @(negedge clk);
    chk("odd_end_tx", 32'(tx[2]), 32'd1);
    chk("odd_end_busy", 32'(busy[2]), 32'd0);

    // FIFO fill, drop while full, back-to-back frames
    fork
      begin
        push(0, 8'hA5, 1'b1);
        push(0, 8'h0F, 1'b1);
        push(0, 8'hFF, 1'b1);
        push(0, 8'h00, 1'b1);
        push(0, 8'h81, 1'b1);
        chk("full_ready", 32'(ready[0]), 32'd0);
        chk("full_count", 32'(count0), 32'd4);
        push(0, 8'h3C, 1'b0);
        chk("drop_count", 32'(count0), 32'd4);
        chk("drop_busy", 32'(busy[0]), 32'd1);
      end
      begin
        check_frame(0, 1'b0, "b2b0");
        check_frame(0, 1'b1, "b2b1");
        check_frame(0, 1'b1, "b2b2");
        check_frame(0, 1'b1, "b2b3");
        check_frame(0, 1'b1, "b2b4");
      end
    join
    @(negedge clk);
    chk("b2b_end_tx", 32'(tx[0]), 32'd1);
    chk("b2b_end_busy", 32'(busy[0]), 32'd0);
    chk("b2b_end_count", 32'(count0), 32'd0);

    // push coinciding with the end-of-stop pop
    fork
      begin
        push(0, 8'h11, 1'b1);
        push(0, 8'h22, 1'b1);
        chk("pp_count_pre", 32'(count0), 32'd1);
        repeat (39) @(negedge clk);
        chk("pp_count_wait", 32'(count0), 32'd1);
        push(0, 8'h33, 1'b1);
        chk("pp_count_same", 32'(count0), 32'd1);
      end
      begin
        check_frame(0, 1'b0, "pp0");
        check_frame(0, 1'b1, "pp1");
        check_frame(0, 1'b1, "pp2");
      end
    join
    @(negedge clk);
    chk("pp_end_busy", 32'(busy[0]), 32'd0);

    // reset in the middle of data bit 3
    push(0, 8'h77, 1'b0);
    repeat (18) @(negedge clk);
    chk("mid_tx_bit3", 32'(tx[0]), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx[0]), 32'd1);
    chk("mid_rst_count", 32'(count0), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push(0, 8'h5A, 1'b1);
    check_frame(0, 1'b1, "post_rst");
    @(negedge clk);
    chk("post_rst_end_tx", 32'(tx[0]), 32'd1);
    chk("post_rst_end_busy", 32'(busy[0]), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
